// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
//   Serial-to-parallel UART receiver. It accepts 8N1 frames, sent LSB first
//   on an idle-high line. The receiver does these steps in order:
//     - synchronises the asynchronous line through two flops;
//     - confirms the start bit at its centre;
//     - samples the eight data bits at their centres;
//     - checks the stop bit.
//
//   Optional build macro: UART_PARITY_EN
//     When it is defined, the frame becomes 8E1. A PARITY state sits between
//     DATA and STOP, and RX_PERR pulses when the even-parity bit is wrong.
//     When it is undefined, there is no PARITY state and RX_PERR is tied to 0.
//
//   Parameters
//     CLKS_PER_BIT : clk cycles per bit (legal range >= 8)
//     HALF_BIT     : cycles from the detected start edge to the start-bit
//                    centre check
//
//   Ports
//     clk       : system clock; all logic runs on the rising edge
//     rst_n     : asynchronous active-low reset
//     UART_RX   : serial line; asynchronous to clk; idle high
//     RX_DATA   : last correctly framed byte; held until the next good frame
//     RX_STATUS : one-cycle pulse meaning a new byte is valid on RX_DATA
//     RX_FERR   : one-cycle pulse meaning the stop bit was sampled low
//     RX_BUSY   : high whenever the FSM is not in IDLE
//     RX_PERR   : one-cycle parity-error pulse (constant 0 without parity)
//
//   Handshake: there is no back-pressure. RX_STATUS, RX_FERR and RX_PERR are
//   single-cycle strobes, and at most one of them is high in any cycle. The
//   consumer must capture RX_DATA in the cycle where RX_STATUS is high,
//   because the next good frame overwrites it.
//
//   The FSM state is held in r_state. The sampled line is held in r_rx_s.
// ---------------------------------------------------------------------------
module uart_receiver #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       UART_RX,
  output logic [7:0] RX_DATA,
  output logic       RX_STATUS,
  output logic       RX_FERR,
  output logic       RX_BUSY,
  output logic       RX_PERR
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF_END = CW'(HALF_BIT - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  logic          r_rx_meta;
  logic          r_rx_s;
  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bitidx;
  logic [7:0]    r_shreg;
  logic [7:0]    r_data;
  logic          r_status;
  logic          r_ferr;
  logic          w_bit_end;
  logic          w_half_end;

  assign w_bit_end  = (r_cnt == CNT_BIT_END);
  assign w_half_end = (r_cnt == CNT_HALF_END);

  // The synchroniser resets to the idle level. A line that is already idle
  // therefore cannot look like a start edge when reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= UART_RX;
      r_rx_s    <= r_rx_meta;
    end
  end

`ifdef UART_PARITY_EN
  logic r_perr;
  logic r_par_bad;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bitidx  <= '0;
      r_shreg   <= '0;
      r_data    <= '0;
      r_status  <= 1'b0;
      r_ferr    <= 1'b0;
`ifdef UART_PARITY_EN
      r_perr    <= 1'b0;
      r_par_bad <= 1'b0;
`endif
    end else begin
      // The strobes are high for a single cycle. They are cleared here and
      // set again only at the stop-bit decision.
      r_status <= 1'b0;
      r_ferr   <= 1'b0;
`ifdef UART_PARITY_EN
      r_perr   <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (!r_rx_s) begin
            r_state <= ST_START;
          end
        end

        // Re-check the line at the start-bit centre. A short low glitch has
        // ended by then, so it returns the FSM to IDLE without any pulse.
        ST_START: begin
          if (w_half_end) begin
            r_cnt <= '0;
            if (!r_rx_s) begin
              r_state  <= ST_DATA;
              r_bitidx <= '0;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        // The LSB arrives first. Shifting right puts it at bit 0 after the
        // eighth sample.
        ST_DATA: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_shreg <= {r_rx_s, r_shreg[7:1]};
            if (r_bitidx == 3'd7) begin
`ifdef UART_PARITY_EN
              r_state <= ST_PARITY;
`else
              r_state <= ST_STOP;
`endif
            end else begin
              r_bitidx <= r_bitidx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

`ifdef UART_PARITY_EN
        // For even parity, the parity bit must equal the XOR of the data bits.
        ST_PARITY: begin
          if (w_bit_end) begin
            r_cnt     <= '0;
            r_par_bad <= r_rx_s ^ (^r_shreg);
            r_state   <= ST_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif

        // The FSM returns to IDLE at the stop-bit centre. This leaves half a
        // bit of margin to catch a start bit that follows directly.
        ST_STOP: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_rx_s) begin
              r_state <= ST_IDLE;
`ifdef UART_PARITY_EN
              if (r_par_bad) begin
                r_perr <= 1'b1;
              end else begin
                r_data   <= r_shreg;
                r_status <= 1'b1;
              end
`else
              r_data   <= r_shreg;
              r_status <= 1'b1;
`endif
            end else begin
              r_ferr  <= 1'b1;
              r_state <= ST_BREAK;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        // A held-low line (break) stays here. This gives a single framing
        // error and no false starts.
        ST_BREAK: begin
          r_cnt <= '0;
          if (r_rx_s) begin
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign RX_DATA   = r_data;
  assign RX_STATUS = r_status;
  assign RX_FERR   = r_ferr;
  assign RX_BUSY   = (r_state != ST_IDLE);
`ifdef UART_PARITY_EN
  assign RX_PERR   = r_perr;
`else
  assign RX_PERR   = 1'b0;
`endif

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receiver: 8N1 frames, LSB first, idle-high line.
- Companion to the team's UART transmitter. Pairs with it over UART_TX -> UART_RX in loopback and board-level links.
- Synchronises the asynchronous line, validates the start bit at mid-bit, samples 8 data bits at bit centres and checks the stop bit.
- Presents each byte on RX_DATA with a one-cycle RX_STATUS strobe.

Parameters:
- CLKS_PER_BIT, 5208, clk cycles per bit (50 MHz / 9600 baud); legal range >= 8.
- HALF_BIT, CLKS_PER_BIT/2, cycles from detected start edge to start-bit centre check.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- UART_RX  input  1  serial line, asynchronous to clk, idle high
- RX_DATA  output  8  last correctly framed byte, held until the next good frame
- RX_STATUS  output  1  one-cycle pulse: new byte valid on RX_DATA
- RX_FERR  output  1  one-cycle pulse: stop bit sampled low (framing error)
- RX_BUSY  output  1  high whenever state != IDLE
- RX_PERR  output  1  one-cycle parity-error pulse; constant 0 unless UART_PARITY_EN

Behaviour:
- Reset (rst_n low, async):
  - RX_DATA=8'h00; RX_STATUS=0, RX_FERR=0, RX_PERR=0, RX_BUSY=0.
  - state=IDLE; bit counter, cycle counter and shift register cleared.
  - Synchroniser flops reset to 1 (idle), so reset release never looks like a start edge.
- Sync: UART_RX passes through 2 flops giving rx_s. All decisions use rx_s only.
- Cycle counter cnt: counts 0..CLKS_PER_BIT-1 within a bit and is reset to 0 on every state change. Width is ceil(log2(CLKS_PER_BIT)).
- IDLE: when rx_s==0, go to START with cnt=0.
- START:
  - At cnt==HALF_BIT-1, sample rx_s.
  - rx_s==0: go to DATA, cnt=0, bitidx=0.
  - rx_s==1: glitch. Return to IDLE with no output pulse.
- DATA:
  - At cnt==CLKS_PER_BIT-1, shift rx_s into the MSB of shreg (right shift; LSB arrives first), cnt=0, bitidx+1.
  - After bitidx 7 is sampled, go to STOP (or PARITY when the macro is on).
- STOP: at cnt==CLKS_PER_BIT-1, sample rx_s.
  - rx_s==1: RX_DATA<=shreg, RX_STATUS=1 for exactly the next cycle, go to IDLE.
  - rx_s==0: RX_FERR=1 for one cycle, RX_DATA unchanged, go to BREAK.
- BREAK: wait until rx_s==1, then go to IDLE. A held-low line produces a single RX_FERR and no false starts.
- Latency: RX_STATUS rises 2 + HALF_BIT + 9*CLKS_PER_BIT (+1 register) cycles after the UART_RX falling edge, within +-1 cycle.
- Back-to-back frames: a start bit directly after the stop bit must be caught. IDLE is re-entered at stop-bit centre, leaving half a bit of margin.
- No buffering: each good frame overwrites RX_DATA. The consumer must capture it on RX_STATUS.
- RX_STATUS, RX_FERR and RX_PERR are mutually exclusive in any cycle.
- Reset asserted mid-frame aborts immediately. After release, the receiver waits for a fresh falling edge; the rest of the aborted frame produces no RX_STATUS unless it contains a valid-looking start pattern.

Optional Feature:
- Macro UART_PARITY_EN.
- When defined:
  - Frame is 8E1. PARITY state sits between DATA and STOP and samples one bit at cnt==CLKS_PER_BIT-1.
  - Expected parity = XOR of the 8 data bits.
  - On mismatch: the stop bit is still checked. At stop with rx_s==1, pulse RX_PERR instead of RX_STATUS and leave RX_DATA unchanged. At stop with rx_s==0, RX_FERR takes precedence.
  - Latency grows by CLKS_PER_BIT.
- When undefined: no PARITY state is built, RX_PERR is tied to 0, and the frame is 8N1.

Test Plan (CLKS_PER_BIT=16 in sim):
- Reset, then drive byte 8'hA5 8N1 -> one RX_STATUS pulse, RX_DATA=8'hA5, RX_BUSY low afterwards, RX_FERR never high.
- Drive 8'h00, 8'hFF, 8'h55 back to back with no idle gap -> three RX_STATUS pulses with the data in order; no byte dropped.
- Low glitch of 4 cycles on an idle line -> START aborts, no pulses, RX_DATA still holds the previous value.
- Frame 8'h3C with stop bit forced 0, line then held low 40 bit times -> exactly one RX_FERR, RX_DATA unchanged. Next valid 8'h81 after the line returns high -> RX_DATA=8'h81.
- Pull rst_n low during bit 4 of 8'hC3 -> all outputs return to reset values asynchronously. A fresh 8'h12 after release is received correctly.
- With UART_PARITY_EN: 8'h07 with correct even parity bit 1 -> RX_STATUS. The same byte with parity 0 -> RX_PERR, no RX_STATUS, RX_DATA unchanged.
